// File: rtl/sar_pkg.sv
// Shared definitions for the SAR controller: FSM state encoding and the small
// arithmetic helpers used by the step table and the search datapath.
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_RESAMPLE,
    ST_DONE
  } sar_state_e;

  // Binary weight for table entry idx; entries at or above width hold zero.
  function automatic logic [31:0] binary_step(input int idx, input int width);
    if (idx < width && idx < 32) begin
      return 32'd1 << idx;
    end
    return 32'd0;
  endfunction

  // Unsigned add clamped to the largest width-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    if (sum > lim) begin
      return lim[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sar_step_table.sv
// Runtime-programmable step-size table for the successive-approximation search.
// Resets to plain binary weights; one write port, combinational read at the pointer.
module sar_step_table
  import sar_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int MAX_STEPS = 16,
  parameter int PTR_W     = 4
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] step_q [MAX_STEPS];
  logic [WIDTH-1:0] step_d [MAX_STEPS];

  always_comb begin
    for (int i = 0; i < MAX_STEPS; i++) begin
      step_d[i] = (we && (waddr == PTR_W'(i))) ? wdata : step_q[i];
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_STEPS; i++) begin
        step_q[i] <= WIDTH'(binary_step(i, WIDTH));
      end
    end else begin
      for (int i = 0; i < MAX_STEPS; i++) begin
        step_q[i] <= step_d[i];
      end
    end
  end

  // Pointer values beyond the table depth read as a zero step.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < MAX_STEPS) begin
      rdata = step_q[raddr];
    end
  end

endmodule

// File: rtl/sar_fsm_redundant.sv
// Successive-approximation controller with a programmable (possibly redundant)
// step table and 2^k oversampling with accumulate-and-average.
module sar_fsm_redundant
  import sar_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int MAX_STEPS  = 16,
  parameter int PTR_W      = 4,
  parameter int AVG_MAX    = 4,
  parameter int SAMPLE_CYC = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             st_conv,
  input  logic             comp_in,
  output logic             clkout,
  output logic             sample,
  output logic [WIDTH-1:0] dac_value,
  input  logic             cfg_we,
  input  logic [PTR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [PTR_W:0]   cfg_nsteps,
  input  logic [2:0]       avg_log2,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             adc_done
);

  localparam int ACC_W = WIDTH + AVG_MAX;
  localparam int CNT_W = (AVG_MAX > 0) ? AVG_MAX : 1;
  localparam int SC_W  = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  sar_state_e        state_q, state_d;
  logic              st_q, st_d;
  logic [WIDTH-1:0]  code_q, code_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   samp_q, samp_d;
  logic [PTR_W:0]    nsteps_q, nsteps_d;
  logic [2:0]        avg_q, avg_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;

  logic [WIDTH-1:0]  step_rd;
  logic [WIDTH-1:0]  trial_code;
  logic [WIDTH-1:0]  next_code;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  last_cnt;
  logic [PTR_W:0]    nsteps_clamp;
  logic [2:0]        avg_clamp;
  logic              idle_like;
  logic              table_we;
  logic              st_rise;
  logic              st_fall;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign table_we  = cfg_we && idle_like;
  assign st_rise   = st_conv && !st_q;
  assign st_fall   = !st_conv && st_q;

  sar_step_table #(
    .WIDTH     (WIDTH),
    .MAX_STEPS (MAX_STEPS),
    .PTR_W     (PTR_W)
  ) u_step_table (
    .clkin (clkin),
    .rst   (rst),
    .we    (table_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (ptr_q),
    .rdata (step_rd)
  );

  // Trial code is saturated so a redundant table never wraps the DAC input.
  assign trial_code = WIDTH'(sat_add(32'(code_q), 32'(step_rd), WIDTH));
  assign next_code  = comp_in ? trial_code : code_q;
  assign acc_sum    = acc_q + ACC_W'(next_code);
  assign last_cnt   = CNT_W'((32'd1 << avg_q) - 32'd1);

  always_comb begin
    nsteps_clamp = cfg_nsteps;
    if (cfg_nsteps == '0) begin
      nsteps_clamp = (PTR_W + 1)'(1);
    end else if (int'(cfg_nsteps) > MAX_STEPS) begin
      nsteps_clamp = (PTR_W + 1)'(MAX_STEPS);
    end
    avg_clamp = (int'(avg_log2) > AVG_MAX) ? 3'(AVG_MAX) : avg_log2;
  end

  always_comb begin
    state_d        = state_q;
    st_d           = st_conv;
    code_d         = code_q;
    ptr_d          = ptr_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    samp_d         = samp_q;
    nsteps_d       = nsteps_q;
    avg_d          = avg_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (st_rise) begin
          state_d  = ST_SAMPLE;
          nsteps_d = nsteps_clamp;
          avg_d    = avg_clamp;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end

      ST_SAMPLE: begin
        if (st_fall) begin
          state_d = ST_CONV;
          ptr_d   = PTR_W'(nsteps_q - (PTR_W + 1)'(1));
          code_d  = '0;
        end
      end

      ST_CONV: begin
        code_d = next_code;
        if (ptr_q == '0) begin
          acc_d = acc_sum;
          if (cnt_q == last_cnt) begin
            state_d        = ST_DONE;
            result_d       = WIDTH'(acc_sum >> avg_q);
            result_valid_d = 1'b1;
          end else begin
            state_d = ST_RESAMPLE;
            cnt_d   = cnt_q + CNT_W'(1);
            samp_d  = '0;
          end
        end else begin
          ptr_d = ptr_q - PTR_W'(1);
        end
      end

      ST_RESAMPLE: begin
        if (samp_q == SC_W'(SAMPLE_CYC - 1)) begin
          state_d = ST_CONV;
          ptr_d   = PTR_W'(nsteps_q - (PTR_W + 1)'(1));
          code_d  = '0;
        end else begin
          samp_d = samp_q + SC_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      st_q           <= 1'b0;
      code_q         <= '0;
      ptr_q          <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      samp_q         <= '0;
      nsteps_q       <= (PTR_W + 1)'(WIDTH);
      avg_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      st_q           <= st_d;
      code_q         <= code_d;
      ptr_q          <= ptr_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      samp_q         <= samp_d;
      nsteps_q       <= nsteps_d;
      avg_q          <= avg_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // State only moves on the rising edge, so gating the low phase cannot glitch.
  assign clkout       = ~clkin & (state_q == ST_CONV);
  assign sample       = (state_q == ST_SAMPLE) || (state_q == ST_RESAMPLE);
  assign busy         = (state_q == ST_SAMPLE) || (state_q == ST_CONV) ||
                        (state_q == ST_RESAMPLE);
  assign adc_done     = (state_q == ST_DONE);
  assign dac_value    = (state_q == ST_CONV) ? trial_code : code_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sar_fsm_redundant.sv
// Randomized bench for sar_fsm_redundant: an ideal comparator against a random
// input voltage, checked against an arithmetic model of the weighted search.
module tb_sar_fsm_redundant;

  localparam int WIDTH      = 12;
  localparam int MAX_STEPS  = 16;
  localparam int PTR_W      = 4;
  localparam int AVG_MAX    = 4;
  localparam int SAMPLE_CYC = 2;
  localparam int FULL       = (1 << WIDTH) - 1;

  logic             clkin = 1'b0;
  logic             rst = 1'b1;
  logic             st_conv = 1'b0;
  logic             comp_in = 1'b0;
  logic             cfg_we = 1'b0;
  logic [PTR_W-1:0] cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic [PTR_W:0]   cfg_nsteps = 5'd12;
  logic [2:0]       avg_log2 = 3'd0;
  logic             clkout;
  logic             sample;
  logic [WIDTH-1:0] dac_value;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;
  logic             adc_done;

  int checks = 0;
  int errors = 0;
  int tbl[MAX_STEPS];

  sar_fsm_redundant #(
    .WIDTH      (WIDTH),
    .MAX_STEPS  (MAX_STEPS),
    .PTR_W      (PTR_W),
    .AVG_MAX    (AVG_MAX),
    .SAMPLE_CYC (SAMPLE_CYC)
  ) dut (
    .clkin        (clkin),
    .rst          (rst),
    .st_conv      (st_conv),
    .comp_in      (comp_in),
    .clkout       (clkout),
    .sample       (sample),
    .dac_value    (dac_value),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_nsteps   (cfg_nsteps),
    .avg_log2     (avg_log2),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .adc_done     (adc_done)
  );

  always #5 clkin = ~clkin;

  task automatic tick();
    @(negedge clkin);
    #1;
  endtask

  task automatic set_binary_model();
    for (int i = 0; i < MAX_STEPS; i++) tbl[i] = (i < WIDTH) ? (1 << i) : 0;
  endtask

  task automatic load_table();
    for (int i = 0; i < MAX_STEPS; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = PTR_W'(i);
      cfg_data = WIDTH'(tbl[i]);
      tick();
    end
    cfg_we = 1'b0;
  endtask

  // One full start-to-result transaction. The model walks the table from the
  // top entry down, keeping a trial only when the ideal comparator says vin >= trial.
  task automatic run_adc(input int n_cfg, input int a_cfg, input int vin0, input bit rand_vin,
                         input bit poke, input bit wr, input int wr_addr, input int wr_data,
                         input string name);
    int n, a, nconv, acc, partial, trial, vin, exp_res;
    n = (n_cfg < 1) ? 1 : ((n_cfg > MAX_STEPS) ? MAX_STEPS : n_cfg);
    a = (a_cfg > AVG_MAX) ? AVG_MAX : a_cfg;
    nconv = 1 << a;
    acc = 0;
    cfg_nsteps = 5'(n_cfg);
    avg_log2   = 3'(a_cfg);
    st_conv    = 1'b1;
    if (wr) begin
      cfg_we   = 1'b1;
      cfg_addr = PTR_W'(wr_addr);
      cfg_data = WIDTH'(wr_data);
      tbl[wr_addr] = wr_data;
    end
    tick();
    cfg_we = 1'b0;
    checks++;
    if (busy !== 1'b1 || sample !== 1'b1 || adc_done !== 1'b0 || clkout !== 1'b0) begin
      errors++;
      $display("FAIL %s sample_phase: busy=%b sample=%b done=%b clkout=%b, want 1 1 0 0",
               name, busy, sample, adc_done, clkout);
    end
    st_conv    = 1'b0;
    cfg_nsteps = 5'($urandom);
    avg_log2   = 3'($urandom);
    for (int k = 0; k < nconv; k++) begin
      vin = rand_vin ? int'($urandom_range(0, FULL)) : vin0;
      partial = 0;
      for (int j = n - 1; j >= 0; j--) begin
        tick();
        trial = (partial + tbl[j] > FULL) ? FULL : partial + tbl[j];
        checks++;
        if (dac_value !== WIDTH'(trial) || busy !== 1'b1 || sample !== 1'b0 ||
            clkout !== 1'b1) begin
          errors++;
          $display("FAIL %s conv%0d step%0d: dac=%0d busy=%b sample=%b clkout=%b, want dac=%0d 1 0 1",
                   name, k, j, dac_value, busy, sample, clkout, trial);
        end
        comp_in = (vin >= trial);
        if (vin >= trial) partial = trial;
        if (poke && k == 0 && j == n - 3) begin
          cfg_we   = 1'b1;
          cfg_addr = PTR_W'($urandom);
          cfg_data = WIDTH'($urandom);
          st_conv  = 1'b1;
        end else begin
          cfg_we  = 1'b0;
          st_conv = 1'b0;
        end
      end
      acc += partial;
      if (k < nconv - 1) begin
        for (int s = 0; s < SAMPLE_CYC; s++) begin
          tick();
          checks++;
          if (sample !== 1'b1 || busy !== 1'b1 || clkout !== 1'b0 || adc_done !== 1'b0) begin
            errors++;
            $display("FAIL %s resample%0d.%0d: sample=%b busy=%b clkout=%b done=%b, want 1 1 0 0",
                     name, k, s, sample, busy, clkout, adc_done);
          end
        end
      end
    end
    cfg_we  = 1'b0;
    st_conv = 1'b0;
    exp_res = acc >> a;
    tick();
    checks++;
    if (adc_done !== 1'b1 || result_valid !== 1'b1 || busy !== 1'b0 ||
        result !== WIDTH'(exp_res)) begin
      errors++;
      $display("FAIL %s done_entry: done=%b valid=%b busy=%b result=%0d, want 1 1 0 %0d",
               name, adc_done, result_valid, busy, result, exp_res);
    end
    tick();
    checks++;
    if (adc_done !== 1'b1 || result_valid !== 1'b0 || result !== WIDTH'(exp_res)) begin
      errors++;
      $display("FAIL %s done_hold: done=%b valid=%b result=%0d, want 1 0 %0d",
               name, adc_done, result_valid, result, exp_res);
    end
    $display("adc %s: nsteps=%0d avg=%0d acc=%0d result=%0d expected=%0d",
             name, n, a, acc, result, exp_res);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, sample, adc_done, result_valid, clkout} !== 5'b0 || result !== '0 ||
        dac_value !== '0) begin
      errors++;
      $display("FAIL reset: flags=%b result=%0d dac=%0d, want 00000 0 0",
               {busy, sample, adc_done, result_valid, clkout}, result, dac_value);
    end
    tick();
    rst = 1'b0;
    set_binary_model();
    tick();
  endtask

  task automatic test_full_scale();
    run_adc(12, 0, FULL, 1'b0, 1'b0, 1'b0, 0, 0, "full_scale");
  endtask

  task automatic test_binary_code();
    run_adc(12, 0, 'hA5C, 1'b0, 1'b0, 1'b0, 0, 0, "code_a5c");
    for (int r = 0; r < 3; r++) run_adc(12, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, "binary_rand");
    run_adc(12, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, "zero_scale");
  endtask

  task automatic test_oversample();
    run_adc(12, 2, 2048, 1'b0, 1'b0, 1'b0, 0, 0, "avg4_msb");
    run_adc(12, 1, 0, 1'b1, 1'b0, 1'b0, 0, 0, "avg2_rand");
  endtask

  task automatic test_clamps();
    run_adc(0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, "nsteps0");
    run_adc(20, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, "nsteps20");
    run_adc(5, 7, 0, 1'b1, 1'b0, 1'b0, 0, 0, "avg7");
  endtask

  task automatic test_redundant_table();
    int red[14] = '{1, 2, 3, 4, 8, 14, 26, 45, 80, 144, 253, 456, 1011, 2048};
    for (int i = 0; i < MAX_STEPS; i++) tbl[i] = (i < 14) ? red[i] : 0;
    load_table();
    run_adc(14, 0, FULL, 1'b0, 1'b0, 1'b0, 0, 0, "redundant_full");
    for (int r = 0; r < 3; r++) run_adc(14, r, 0, 1'b1, 1'b0, 1'b0, 0, 0, "redundant_rand");
  endtask

  task automatic test_busy_ignore();
    run_adc(14, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, "write_while_busy");
    run_adc(14, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, "table_unchanged");
  endtask

  task automatic test_write_with_start();
    run_adc(14, 0, 0, 1'b1, 1'b0, 1'b1, 13, 1500, "write_and_start");
    run_adc(14, 0, FULL, 1'b0, 1'b0, 1'b1, 12, 900, "write_and_start_full");
  endtask

  task automatic test_random_tables();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < MAX_STEPS; i++) begin
        tbl[i] = int'($urandom_range(0, 1 << ((i < 11) ? i + 1 : 11)));
      end
      load_table();
      run_adc(int'($urandom_range(4, 16)), int'($urandom_range(0, 2)), 0, 1'b1,
              r[0], 1'b0, 0, 0, "random_table");
    end
  endtask

  task automatic test_reset_mid_conv();
    cfg_nsteps = 5'd12;
    avg_log2   = 3'd0;
    st_conv    = 1'b1;
    tick();
    st_conv = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      comp_in = 1'($urandom);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, sample, adc_done, result_valid, clkout} !== 5'b0 || result !== '0 ||
        dac_value !== '0) begin
      errors++;
      $display("FAIL reset_mid_conv: flags=%b result=%0d dac=%0d, want 00000 0 0",
               {busy, sample, adc_done, result_valid, clkout}, result, dac_value);
    end
    tick();
    rst = 1'b0;
    set_binary_model();
    tick();
    run_adc(12, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, "after_reset_binary");
    run_adc(16, 0, FULL, 1'b0, 1'b0, 1'b0, 0, 0, "after_reset_upper_zero");
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_binary_code();
    test_oversample();
    test_clamps();
    test_redundant_table();
    test_busy_ignore();
    test_write_with_start();
    test_random_tables();
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
